// File: rtl/sha256_msg_padder.sv
// SHA-256 front end: streams message bytes into the 1024-byte message RAM and appends 0x80, zero fill and the 64-bit bit length.
// Writes are registered, one byte per cycle; in_ready is high only while loading message bytes.
module sha256_msg_padder #(
    parameter int ADDR_W  = 10,
    parameter int MAX_MSG = 1015
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              empty_msg,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic [4:0]        n_blocks,
    output logic              err_len
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PAD80 = 3'd2,
        ZERO  = 3'd3,
        LEN   = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] msg_len;
    logic [ADDR_W-1:0] cnt_inc;
    logic [63:0]       bit_len;
    logic [7:0]        len_byte;
    logic              at_len_slot;
    logic              accept;

    assign in_ready    = (state == LOAD);
    assign accept      = in_valid && in_ready;
    assign cnt_inc     = cnt + 1'b1;
    assign at_len_slot = (cnt_inc[5:0] == 6'd56);
    assign bit_len     = 64'(msg_len) << 3;
    // Length slots start at offset 56, so cnt[2:0] is the byte index, MSB first.
    assign len_byte    = 8'(bit_len >> {~cnt[2:0], 3'b000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            msg_len  <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            n_blocks <= 5'd0;
            err_len  <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        msg_len  <= '0;
                        err_len  <= 1'b0;
                        n_blocks <= 5'd0;
                        busy     <= 1'b1;
                        state    <= empty_msg ? PAD80 : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt == ADDR_W'(MAX_MSG)) begin
                            // Padded message would not fit: drop the byte and abort.
                            err_len <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            we    <= 1'b1;
                            waddr <= cnt;
                            wdata <= in_data;
                            cnt   <= cnt_inc;
                            if (in_last) begin
                                msg_len <= cnt_inc;
                                state   <= PAD80;
                            end
                        end
                    end
                end
                PAD80: begin
                    we    <= 1'b1;
                    waddr <= cnt;
                    wdata <= 8'h80;
                    cnt   <= cnt_inc;
                    state <= at_len_slot ? LEN : ZERO;
                end
                ZERO: begin
                    we    <= 1'b1;
                    waddr <= cnt;
                    wdata <= 8'h00;
                    cnt   <= cnt_inc;
                    if (at_len_slot) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    we    <= 1'b1;
                    waddr <= cnt;
                    wdata <= len_byte;
                    cnt   <= cnt_inc;
                    if (cnt[2:0] == 3'd7) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    // A full RAM wraps cnt to zero, which stands for the maximum block count.
                    if (cnt[ADDR_W-1:6] == '0) begin
                        n_blocks <= 5'(2 ** (ADDR_W - 6));
                    end else begin
                        n_blocks <= 5'(cnt[ADDR_W-1:6]);
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed padding images checked against a captured RAM image.
module tb_sha256_msg_padder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       empty_msg = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       we;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [4:0] n_blocks;
    logic       err_len;

    int total = 0;
    int bad = 0;

    sha256_msg_padder #(.ADDR_W(10), .MAX_MSG(1015)) dut (
        .clk(clk), .rst(rst), .start(start), .empty_msg(empty_msg),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .n_blocks(n_blocks), .err_len(err_len)
    );

    always #5 clk = ~clk;

    // Write monitor: captures the RAM image and counts pulses, sampled mid-cycle.
    logic [7:0] mem [0:1023];
    int wcount = 0;
    int dcount = 0;
    int bad_addr = 0;
    int nb_seen = 0;
    int exp_addr = 0;

    always @(negedge clk) begin
        if (start && !busy && !rst) exp_addr = 0;
        if (we) begin
            mem[waddr] = wdata;
            if (int'(waddr) != (exp_addr % 1024)) bad_addr++;
            exp_addr++;
            wcount++;
        end
        if (done) begin
            dcount++;
            nb_seen = int'(n_blocks);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic do_start(input bit em);
        @(posedge clk); #1;
        start = 1'b1; empty_msg = em;
        @(posedge clk); #1;
        start = 1'b0; empty_msg = 1'b0;
    endtask

    task automatic feed(input string tag, input int n, input logic [7:0] base,
                        input int gap, input bit last_on_n);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < n && guard < 20000) begin
            in_valid = (gap == 0) || ($urandom_range(99) >= gap);
            in_data  = base + 8'(i);
            in_last  = last_on_n && (i == n - 1);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_feed_bound"}, int'(guard < 20000), 1);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (dcount == d0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, int'(dcount != d0), 1);
    endtask

    task automatic check_run(input string tag, input int len, input logic [7:0] base,
                             input int nb, input logic [7:0] hi, input logic [7:0] lo,
                             input int w0, input int d0, input int b0);
        int nz = 0;
        wait_done(tag, d0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_busy_low"}, int'(busy), 0);
        repeat (3) @(negedge clk);
        chk({tag, "_done_count"}, dcount - d0, 1);
        chk({tag, "_n_blocks"}, nb_seen, nb);
        chk({tag, "_n_blocks_hold"}, int'(n_blocks), nb);
        chk({tag, "_writes"}, wcount - w0, 64 * nb);
        chk({tag, "_addr_contig"}, bad_addr - b0, 0);
        if (len > 0) begin
            chk({tag, "_first_byte"}, int'(mem[0]), int'(base));
            chk({tag, "_last_byte"}, int'(mem[len - 1]), int'(8'(base + 8'(len - 1))));
        end
        chk({tag, "_pad80"}, int'(mem[len]), 8'h80);
        for (int i = len + 1; i < 64 * nb - 2; i++) if (mem[i] != 8'h00) nz++;
        chk({tag, "_zero_fill"}, nz, 0);
        chk({tag, "_len_hi"}, int'(mem[64 * nb - 2]), int'(hi));
        chk({tag, "_len_lo"}, int'(mem[64 * nb - 1]), int'(lo));
    endtask

    initial begin
        int w0, d0, b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", int'(we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_n_blocks", int'(n_blocks), 0);
        chk("rst_err_len", int'(err_len), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_in_ready", int'(in_ready), 0);

        // "abc"
        w0 = wcount; d0 = dcount; b0 = bad_addr;
        do_start(1'b0);
        chk("abc_busy", int'(busy), 1);
        chk("abc_in_ready", int'(in_ready), 1);
        feed("abc", 3, 8'h61, 0, 1'b1);
        check_run("abc", 3, 8'h61, 1, 8'h00, 8'h18, w0, d0, b0);
        chk("abc_in_ready_after", int'(in_ready), 0);

        // empty message
        w0 = wcount; d0 = dcount; b0 = bad_addr;
        do_start(1'b1);
        chk("empty_in_ready", int'(in_ready), 0);
        check_run("empty", 0, 8'h00, 1, 8'h00, 8'h00, w0, d0, b0);

        // L = 55: everything fits in one block
        w0 = wcount; d0 = dcount; b0 = bad_addr;
        do_start(1'b0);
        feed("l55", 55, 8'h10, 0, 1'b1);
        check_run("l55", 55, 8'h10, 1, 8'h01, 8'hB8, w0, d0, b0);

        // L = 56: length no longer fits, spills to a second block
        w0 = wcount; d0 = dcount; b0 = bad_addr;
        do_start(1'b0);
        feed("l56", 56, 8'h20, 0, 1'b1);
        check_run("l56", 56, 8'h20, 2, 8'h01, 8'hC0, w0, d0, b0);

        // L = 100 with random in_valid gaps
        w0 = wcount; d0 = dcount; b0 = bad_addr;
        do_start(1'b0);
        feed("l100", 100, 8'h33, 35, 1'b1);
        check_run("l100", 100, 8'h33, 2, 8'h03, 8'h20, w0, d0, b0);

        // L = 1015: fills the RAM exactly
        w0 = wcount; d0 = dcount; b0 = bad_addr;
        do_start(1'b0);
        feed("l1015", 1015, 8'h05, 0, 1'b1);
        check_run("l1015", 1015, 8'h05, 16, 8'h1F, 8'hB8, w0, d0, b0);

        // L = 1016: overflow byte is dropped
        w0 = wcount; d0 = dcount;
        do_start(1'b0);
        feed("l1016", 1016, 8'h07, 0, 1'b1);
        repeat (20) @(negedge clk);
        chk("l1016_err_len", int'(err_len), 1);
        chk("l1016_busy", int'(busy), 0);
        chk("l1016_in_ready", int'(in_ready), 0);
        chk("l1016_no_done", dcount - d0, 0);
        chk("l1016_writes", wcount - w0, 1015);

        // reset in the middle of LOAD
        do_start(1'b0);
        chk("rstmid_err_cleared", int'(err_len), 0);
        feed("rstmid", 10, 8'h40, 0, 1'b0);
        chk("rstmid_we_before", int'(we), 1);
        rst = 1'b1;
        #1;
        chk("rstmid_we_async", int'(we), 0);
        chk("rstmid_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // "abc" again, with a stray start while busy that must be ignored
        w0 = wcount; d0 = dcount; b0 = bad_addr;
        do_start(1'b0);
        start = 1'b1; empty_msg = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; empty_msg = 1'b0;
        chk("abc2_still_loading", int'(in_ready), 1);
        feed("abc2", 3, 8'h61, 0, 1'b1);
        check_run("abc2", 3, 8'h61, 1, 8'h00, 8'h18, w0, d0, b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Front end of the SHA-256 core: accepts a byte stream, writes it into the 1024-byte message RAM one byte per cycle, and appends the standard padding.
- Padding is a 0x80 byte, then zeros, then the 64-bit big-endian message bit length.
- Reports the number of 512-bit blocks written so the hash controller can read 32-bit words per block.

Parameters:
- ADDR_W, 10, RAM byte-address width (1024 bytes).
- MAX_MSG, 1015, largest message in bytes whose padded form fits the RAM (1024 - 9).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  begin a new message; honoured in IDLE only
- empty_msg  input  1  sampled with start; 1 = zero-length message, skip LOAD
- in_valid  input  1  input byte valid
- in_data  input  8  input byte
- in_last  input  1  marks final byte, qualified by in_valid and in_ready
- in_ready  output  1  padder accepts a byte this cycle
- we  output  1  RAM write enable
- waddr  output  ADDR_W  RAM byte address
- wdata  output  8  RAM write byte
- busy  output  1  high from the start acceptance until done or error
- done  output  1  one-cycle pulse when padding is complete
- n_blocks  output  5  padded length / 64 (1..16); valid from done until the next start
- err_len  output  1  sticky overflow flag, cleared by the next accepted start

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state IDLE; byte counter cnt = 0; all outputs 0.
- States: IDLE, LOAD, PAD80, ZERO, LEN, FIN.
- IDLE:
  - start=1 clears cnt and err_len.
  - Next state is PAD80 if empty_msg=1, else LOAD.
  - start while not IDLE is ignored.
- LOAD:
  - in_ready=1 (combinational, state-only). A byte is accepted when in_valid && in_ready.
  - Each accepted byte gives, on the next cycle, we=1, waddr=cnt, wdata=in_data; cnt then increments.
  - Cycles with no accepted byte give we=0 on the following cycle.
  - An accepted byte with in_last=1 moves the state to PAD80; the message length L = cnt after that byte.
  - An accepted byte while cnt == MAX_MSG is dropped: no write, err_len=1, busy=0, return to IDLE, no done.
- PAD80: one write of 0x80 at cnt; cnt++; go to ZERO.
- ZERO: while cnt[5:0] != 56, write 0x00 at cnt and increment cnt. When cnt[5:0] == 56, go to LEN with no idle cycle.
- LEN:
  - Eight consecutive writes at cnt..cnt+7 of the 64-bit value L*8, most significant byte first.
  - Bits above bit 12 are always zero.
- FIN:
  - Entered after the last LEN write is presented.
  - done=1 for one cycle; n_blocks = cnt[ADDR_W-1:6], which gives 16 when cnt wraps to 0 at 1024.
  - busy drops in the same cycle; return to IDLE.
- Write timing:
  - we, waddr and wdata are registered. we is high for exactly one cycle per byte.
  - Padding writes occur on back-to-back cycles.
  - Total writes per message = 64*n_blocks. Addresses are contiguous from 0 with no gaps or repeats.
- Block count: n_blocks = ceil((L+9)/64).
- in_ready=0 in every state except LOAD; in_data is ignored elsewhere.
- Reset mid-operation:
  - All state returns to IDLE immediately; we deasserts asynchronously.
  - Partial RAM contents are don't-care.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63):
  - Writes 0x61/0x62/0x63 at 0..2, 0x80 at 3, 0x00 at 4..62, 0x18 at 63.
  - n_blocks=1, 64 we pulses, one done pulse.
- Empty message (start with empty_msg=1): 0x80 at 0, 0x00 at 1..63, n_blocks=1.
- L=55: 0x80 at 55, 0x01 at 62, 0xB8 at 63, n_blocks=1.
- L=56: 0x80 at 56, zeros through 125, 0x01 at 126, 0xC0 at 127, n_blocks=2.
- Random in_valid gaps on a 100-byte message:
  - Only accepted bytes are written, addresses contiguous.
  - Length 0x0320 at 126..127, n_blocks=2.
- L=1015: last write addr 1023; 0x1F at 1022, 0xB8 at 1023; n_blocks=16.
- L=1016: the 1016th byte is dropped, err_len=1, no done, in_ready=0 afterwards.
- Assert rst during LOAD after 10 bytes: we=0 immediately, busy=0; start is ignored while busy. A following "abc" run matches the first scenario.
